// File: rtl/io_bus_responder.sv
// io_bus_responder
//   Single-initiator IO bus slave with a 16-byte register window at
//   io_address[15:4] == BASE_ADDR. It provides an ID register, a scratch
//   register, a control register, a status register, a word FIFO and a
//   down-counting timer with a level interrupt.
//
//   Every request is acknowledged, including out-of-window requests, so the
//   bus can never hang. Each transfer moves through IDLE -> ACK -> HOLD.
//
// Ports
//   clk_clk         : clock; all logic runs on its rising edge
//   reset_reset_n   : synchronous active-low reset
//   io_address      : byte address ([15:4] window, [3:1] register, [0] unused)
//   io_bus_enable   : request; held by the initiator until acknowledged
//   io_byte_enable  : write byte lanes ([1] upper, [0] lower)
//   io_rw           : 1 = read, 0 = write
//   io_write_data   : write data
//   io_read_data    : registered read data, valid while io_acknowledge is high
//   io_acknowledge  : one-cycle transfer-complete pulse
//   io_irq          : registered level interrupt
module io_bus_responder #(
   parameter logic [11:0] BASE_ADDR  = 12'h000,
   parameter logic [15:0] ID_VALUE   = 16'hD15C,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic [15:0] io_address,
   input  logic        io_bus_enable,
   input  logic [1:0]  io_byte_enable,
   input  logic        io_rw,
   input  logic [15:0] io_write_data,
   output logic [15:0] io_read_data,
   output logic        io_acknowledge,
   output logic        io_irq
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

   typedef enum logic [2:0] {
      REG_ID      = 3'd0,
      REG_SCRATCH = 3'd1,
      REG_CTRL    = 3'd2,
      REG_STATUS  = 3'd3,
      REG_FIFO    = 3'd4,
      REG_RELOAD  = 3'd5,
      REG_COUNT   = 3'd6,
      REG_RSVD    = 3'd7
   } reg_t;

   state_t        state, state_next;

   logic [15:0]   scratch;
   logic [2:0]    ctrl;
   logic [15:0]   reload;
   logic [15:0]   count;
   logic          tpend, ovf, err;

   logic [15:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] fifo_cnt;
   logic          fifo_empty, fifo_full;

   logic          accept, in_window, wr_hit, rd_hit;
   reg_t          reg_sel;
   logic          fifo_wr_req, push, pop, ovf_set, err_set;
   logic          tpend_set, reload_wr, status_wr;
   logic [15:0]   push_data, reload_new, rdata;
   logic [4:0]    cnt_ext;
   logic [3:0]    cnt_field;
   logic          unused_addr_lsb;

   function automatic logic [15:0] byte_merge(input logic [15:0] old,
                                               input logic [15:0] wd,
                                               input logic [1:0]  be);
      byte_merge = {be[1] ? wd[15:8] : old[15:8],
                    be[0] ? wd[7:0]  : old[7:0]};
   endfunction

   // ---------------- transfer FSM ----------------
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) state <= S_IDLE;
      else                state <= state_next;
   end

   always_comb begin
      state_next     = state;
      io_acknowledge = 1'b0;
      case (state)
         S_IDLE: if (io_bus_enable) state_next = S_ACK;
         S_ACK: begin
            io_acknowledge = 1'b1;
            state_next     = S_HOLD;
         end
         S_HOLD: if (!io_bus_enable) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- access decode ----------------
   assign unused_addr_lsb = io_address[0];
   assign accept    = (state == S_IDLE) && io_bus_enable;
   assign in_window = (io_address[15:4] == BASE_ADDR);
   assign reg_sel   = reg_t'(io_address[3:1]);
   assign wr_hit    = accept && !io_rw && in_window;
   assign rd_hit    = accept &&  io_rw && in_window;
   assign err_set   = accept && !in_window;

   // ---------------- FIFO ----------------
   assign fifo_empty  = (fifo_cnt == '0);
   assign fifo_full   = (fifo_cnt == CW'(FIFO_DEPTH));
   assign fifo_wr_req = wr_hit && (reg_sel == REG_FIFO) && (io_byte_enable != 2'b00);
   assign push        = fifo_wr_req && !fifo_full;
   assign ovf_set     = fifo_wr_req &&  fifo_full;
   assign pop         = rd_hit && (reg_sel == REG_FIFO) && !fifo_empty;
   assign push_data   = {io_byte_enable[1] ? io_write_data[15:8] : 8'h00,
                         io_byte_enable[0] ? io_write_data[7:0]  : 8'h00};

   always_ff @(posedge clk_clk) begin
      if (push) fifo_mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
   end

   // ---------------- timer ----------------
   assign tpend_set  = ctrl[0] && (count == '0);
   assign reload_wr  = wr_hit && (reg_sel == REG_RELOAD);
   assign reload_new = byte_merge(reload, io_write_data, io_byte_enable);
   assign status_wr  = wr_hit && (reg_sel == REG_STATUS) && io_byte_enable[0];

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         scratch <= '0;
         ctrl    <= '0;
         reload  <= '0;
         count   <= '0;
         tpend   <= 1'b0;
         ovf     <= 1'b0;
         err     <= 1'b0;
      end else begin
         if (wr_hit && (reg_sel == REG_SCRATCH))
            scratch <= byte_merge(scratch, io_write_data, io_byte_enable);
         if (wr_hit && (reg_sel == REG_CTRL) && io_byte_enable[0])
            ctrl <= io_write_data[2:0];
         if (reload_wr) reload <= reload_new;

         // A RELOAD write takes priority over the running decrement.
         if (reload_wr)
            count <= reload_new;
         else if (ctrl[0])
            count <= (count == '0) ? reload : count - 1'b1;

         // Hardware set beats a coincident write-one-to-clear.
         tpend <= tpend_set | (tpend & ~(status_wr & io_write_data[0]));
         ovf   <= ovf_set   | (ovf   & ~(status_wr & io_write_data[3]));
         err   <= err_set   | (err   & ~(status_wr & io_write_data[4]));
      end
   end

   // ---------------- read path ----------------
   // Count field is 4 bits wide; a depth-16 FIFO saturates it at 15 (FULL shows 16).
   assign cnt_ext   = 5'(fifo_cnt);
   assign cnt_field = cnt_ext[4] ? 4'hF : cnt_ext[3:0];

   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_ID:      rdata = ID_VALUE;
         REG_SCRATCH: rdata = scratch;
         REG_CTRL:    rdata = {13'b0, ctrl};
         REG_STATUS:  rdata = {4'h0, cnt_field, 3'b000, err, ovf, fifo_full, fifo_empty, tpend};
         REG_FIFO:    rdata = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr];
         REG_RELOAD:  rdata = reload;
         REG_COUNT:   rdata = count;
         REG_RSVD:    rdata = '0;
         default:     rdata = '0;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         io_read_data <= '0;
         io_irq       <= 1'b0;
      end else begin
         if (accept) io_read_data <= rd_hit ? rdata : 16'h0000;
         io_irq <= (tpend & ctrl[1]) | (!fifo_empty & ctrl[2]);
      end
   end

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed testbench for io_bus_responder (default parameters, BASE_ADDR=0).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_bus_responder;

   localparam logic [15:0] A_ID      = 16'h0000;
   localparam logic [15:0] A_SCRATCH = 16'h0002;
   localparam logic [15:0] A_CTRL    = 16'h0004;
   localparam logic [15:0] A_STATUS  = 16'h0006;
   localparam logic [15:0] A_FIFO    = 16'h0008;
   localparam logic [15:0] A_RELOAD  = 16'h000A;
   localparam logic [15:0] A_COUNT   = 16'h000C;
   localparam logic [15:0] A_RSVD    = 16'h000E;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n;
   logic [15:0] io_address;
   logic        io_bus_enable;
   logic [1:0]  io_byte_enable;
   logic        io_rw;
   logic [15:0] io_write_data;
   logic [15:0] io_read_data;
   logic        io_acknowledge;
   logic        io_irq;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_clk = ~clk_clk;

   io_bus_responder #(
      .BASE_ADDR  (12'h000),
      .ID_VALUE   (16'hD15C),
      .FIFO_DEPTH (8)
   ) dut (
      .clk_clk        (clk_clk),
      .reset_reset_n  (reset_reset_n),
      .io_address     (io_address),
      .io_bus_enable  (io_bus_enable),
      .io_byte_enable (io_byte_enable),
      .io_rw          (io_rw),
      .io_write_data  (io_write_data),
      .io_read_data   (io_read_data),
      .io_acknowledge (io_acknowledge),
      .io_irq         (io_irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("%s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transfer; request captured at the next rising edge,
   // returns on the falling edge two cycles after that capture edge.
   task automatic xfer(input logic [15:0] addr, input logic rw, input logic [15:0] wd,
                       input logic [1:0] be, output logic [15:0] rd);
      int lat;
      lat = 0;
      rd  = '0;
      io_address     = addr;
      io_rw          = rw;
      io_write_data  = wd;
      io_byte_enable = be;
      io_bus_enable  = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk_clk);
         if (io_acknowledge) begin
            lat = i;
            rd  = io_read_data;
            break;
         end
      end
      check("ack_latency", lat, 1);
      io_bus_enable = 1'b0;
      @(negedge clk_clk);
      @(negedge clk_clk);
   endtask

   task automatic wr(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] be);
      logic [15:0] d;
      xfer(addr, 1'b0, data, be, d);
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
      logic [15:0] d;
      xfer(addr, 1'b1, 16'h0000, 2'b00, d);
      check(tag, d, exp);
   endtask

   initial begin
      reset_reset_n  = 1'b0;
      io_address     = '0;
      io_bus_enable  = 1'b0;
      io_byte_enable = '0;
      io_rw          = 1'b1;
      io_write_data  = '0;
      repeat (3) @(negedge clk_clk);
      check("rst_ack", io_acknowledge, 0);
      check("rst_rdata", io_read_data, 0);
      check("rst_irq", io_irq, 0);
      reset_reset_n = 1'b1;
      @(negedge clk_clk);

      // ID read with request held: one ack, no re-accept
      io_address    = A_ID;
      io_rw         = 1'b1;
      io_bus_enable = 1'b1;
      @(negedge clk_clk);
      check("id_ack", io_acknowledge, 1);
      check("id_data", io_read_data, 16'hD15C);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_clk);
         check("id_no_double_ack", io_acknowledge, 0);
      end
      io_bus_enable = 1'b0;
      @(negedge clk_clk);

      // scratch byte enables, reserved register
      wr(A_SCRATCH, 16'hABCD, 2'b01);
      rd_chk("scratch_lo", A_SCRATCH, 16'h00CD);
      wr(A_SCRATCH, 16'h1234, 2'b10);
      rd_chk("scratch_hi", A_SCRATCH, 16'h12CD);
      wr(A_RSVD, 16'hFFFF, 2'b11);
      rd_chk("rsvd", A_RSVD, 16'h0000);
      rd_chk("status_init", A_STATUS, 16'h0002);

      // FIFO fill past full, drain past empty
      for (int i = 1; i <= 9; i++) wr(A_FIFO, 16'(i), 2'b11);
      rd_chk("status_full", A_STATUS, 16'h080C);
      for (int i = 1; i <= 8; i++) rd_chk("fifo_pop", A_FIFO, 16'(i));
      rd_chk("fifo_pop_empty", A_FIFO, 16'h0000);
      rd_chk("status_drained", A_STATUS, 16'h000A);
      wr(A_STATUS, 16'h0008, 2'b11);
      rd_chk("status_ovf_clr", A_STATUS, 16'h0002);
      wr(A_FIFO, 16'hAB12, 2'b01);
      wr(A_FIFO, 16'hFFFF, 2'b00);
      rd_chk("status_be0_push", A_STATUS, 16'h0100);
      rd_chk("fifo_be_lo", A_FIFO, 16'h0012);
      rd_chk("status_be_empty", A_STATUS, 16'h0002);

      // FIFO-not-empty interrupt
      wr(A_CTRL, 16'h0004, 2'b11);
      rd_chk("ctrl_rd", A_CTRL, 16'h0004);
      check("irq_fifo_idle", io_irq, 0);
      wr(A_FIFO, 16'h0055, 2'b11);
      check("irq_fifo_set", io_irq, 1);
      rd_chk("fifo_irq_pop", A_FIFO, 16'h0055);
      check("irq_fifo_clr", io_irq, 0);
      wr(A_CTRL, 16'h0000, 2'b11);

      // out-of-window accesses
      rd_chk("oow_rdata", 16'hFFF0, 16'h0000);
      rd_chk("status_err", A_STATUS, 16'h0012);
      wr(A_STATUS, 16'h0010, 2'b11);
      rd_chk("status_err_clr", A_STATUS, 16'h0002);
      wr(16'h0012, 16'hFFFF, 2'b11);
      rd_chk("oow_write_ignored", A_SCRATCH, 16'h12CD);
      wr(A_STATUS, 16'h0010, 2'b11);

      // RELOAD write loads COUNT
      wr(A_RELOAD, 16'h0005, 2'b11);
      rd_chk("count_loaded", A_COUNT, 16'h0005);
      rd_chk("reload_rd", A_RELOAD, 16'h0005);

      // timer: RELOAD=3 -> TPEND every 4 cycles; Pc = CTRL capture edge
      wr(A_RELOAD, 16'h0003, 2'b11);
      wr(A_CTRL, 16'h0003, 2'b11);
      check("tmr_irq_pc2", io_irq, 0);
      @(negedge clk_clk);
      check("tmr_irq_pc3", io_irq, 0);
      @(negedge clk_clk);
      check("tmr_irq_pc4", io_irq, 0);
      @(negedge clk_clk);
      check("tmr_irq_pc5", io_irq, 1);
      wr(A_STATUS, 16'h0001, 2'b11);        // clear at Pc+6
      check("tmr_irq_pc8", io_irq, 0);
      @(negedge clk_clk);
      check("tmr_irq_pc9", io_irq, 1);      // set again at Pc+8
      @(negedge clk_clk);
      @(negedge clk_clk);
      wr(A_STATUS, 16'h0001, 2'b11);        // clear coincides with set at Pc+12
      rd_chk("tpend_set_wins", A_STATUS, 16'h0003);
      rd_chk("count_running", A_COUNT, 16'h0002);
      wr(A_CTRL, 16'h0000, 2'b11);          // stop at Pc+21
      rd_chk("count_hold", A_COUNT, 16'h0002);
      wr(A_STATUS, 16'h0001, 2'b11);
      rd_chk("status_tpend_clr", A_STATUS, 16'h0002);
      check("irq_stopped", io_irq, 0);

      // reset during ACK, request still held afterwards
      wr(A_SCRATCH, 16'h5A5A, 2'b11);
      wr(A_FIFO, 16'h0077, 2'b11);
      wr(A_CTRL, 16'h0004, 2'b11);
      check("pre_rst_irq", io_irq, 1);
      io_address    = A_ID;
      io_rw         = 1'b1;
      io_bus_enable = 1'b1;
      @(negedge clk_clk);
      check("pre_rst_ack", io_acknowledge, 1);
      reset_reset_n = 1'b0;
      @(negedge clk_clk);
      check("mid_rst_ack", io_acknowledge, 0);
      check("mid_rst_rdata", io_read_data, 0);
      check("mid_rst_irq", io_irq, 0);
      reset_reset_n = 1'b1;
      @(negedge clk_clk);
      check("post_rst_accept", io_acknowledge, 1);
      check("post_rst_data", io_read_data, 16'hD15C);
      io_bus_enable = 1'b0;
      @(negedge clk_clk);
      @(negedge clk_clk);
      rd_chk("rst_scratch", A_SCRATCH, 16'h0000);
      rd_chk("rst_ctrl", A_CTRL, 16'h0000);
      rd_chk("rst_reload", A_RELOAD, 16'h0000);
      rd_chk("rst_count", A_COUNT, 16'h0000);
      rd_chk("rst_status", A_STATUS, 16'h0002);
      rd_chk("rst_fifo", A_FIFO, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/io_bus_responder.md
IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'h000, matched against io_address[15:4] to select this block.
REQ-002 SHALL have parameter ID_VALUE, default 16'hD15C, the value returned by the ID register.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, the word FIFO depth (power of two, 2..16).
REQ-004 clk_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_reset_n  in  1  synchronous, active-low reset.
REQ-006 io_address  in  16  byte address; [15:4] window, [3:1] register select, [0] ignored.
REQ-007 io_bus_enable  in  1  initiator request; held high until io_acknowledge is seen.
REQ-008 io_byte_enable  in  2  [1] upper byte, [0] lower byte of the write data.
REQ-009 io_rw  in  1  1 = read, 0 = write.
REQ-010 io_write_data  in  16  write data.
REQ-011 io_read_data  out  16  registered read data, valid while io_acknowledge is high.
REQ-012 io_acknowledge  out  1  one-cycle transfer-complete pulse.
REQ-013 io_irq  out  1  registered, level interrupt request.

Function
REQ-014 SHALL implement FSM IDLE -> ACK -> HOLD -> IDLE.
- IDLE: io_bus_enable=1 captures the request and performs the write or latches read data -> ACK.
- ACK: io_acknowledge=1 for exactly one cycle -> HOLD.
- HOLD: waits for io_bus_enable=0 -> IDLE.
- Result: acknowledge occurs 1 cycle after capture; no double-accept.
REQ-015 SHALL acknowledge every request, in or out of window, so the bus never hangs.
REQ-016 Out-of-window requests SHALL read 16'h0000, ignore writes, and set sticky ERR.
REQ-017 SHALL implement this register map (offset, access):
- 0x0 ID, RO: ID_VALUE.
- 0x2 SCRATCH, RW: per-byte enables honoured.
- 0x4 CTRL, RW, bits [2:0]: [0] timer run, [1] timer irq enable, [2] FIFO-not-empty irq enable.
- 0x6 STATUS: [0] TPEND (W1C), [1] EMPTY (RO), [2] FULL (RO), [3] OVF (W1C), [4] ERR (W1C), [11:8] count (RO).
- 0x8 FIFO: write pushes, read pops.
- 0xA RELOAD, RW: per-byte enables.
- 0xC COUNT, RO.
- 0xE reserved: reads 0, writes ignored.
REQ-018 A FIFO write SHALL push when io_byte_enable!=0, zeroing disabled bytes; a write with io_byte_enable=0 SHALL be ignored.
REQ-019 A write to a full FIFO SHALL drop the data and set OVF; contents SHALL be unchanged.
REQ-020 A FIFO read SHALL return the head word and pop it; a read of an empty FIFO SHALL return 0 and change nothing.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-022 Timer behaviour while CTRL[0]=1:
- COUNT decrements by 1 each cycle.
- At COUNT=0 it reloads from RELOAD and sets TPEND.
- RELOAD=0 therefore sets TPEND every cycle.
REQ-023 While CTRL[0]=0, COUNT SHALL hold its value.
REQ-024 A write to RELOAD SHALL also load COUNT with the new value in the same cycle, overriding the decrement.
REQ-025 When a W1C clear and a hardware set of the same bit coincide, the set SHALL win.
REQ-026 io_irq SHALL equal the registered value of (TPEND & CTRL[1]) | (!EMPTY & CTRL[2]), one cycle after the condition.
REQ-027 Reads SHALL return the register state from before any side effect of the same access.

Reset
REQ-028 When reset_reset_n=0 at a clock edge:
- FSM returns to IDLE; any in-progress transfer is abandoned.
- io_acknowledge=0, io_read_data=0, io_irq=0.
- SCRATCH, CTRL, RELOAD, COUNT, TPEND, OVF and ERR are cleared.
- FIFO is emptied.
REQ-029 After reset, a request still held on io_bus_enable SHALL be accepted as a new request.

Verification
REQ-030 Read 0x0 at BASE -> single io_acknowledge pulse 1 cycle after capture, io_read_data=16'hD15C, no second ack while io_bus_enable is held.
REQ-031 Write SCRATCH 16'hABCD with byte_enable=2'b01, then read -> 16'h00CD.
REQ-032 Push 9 words into a depth-8 FIFO -> FULL=1, OVF=1, count=8; 8 pops return words 1..8 in order, the 9th pop returns 0, then EMPTY=1.
REQ-033 RELOAD=3, CTRL=3'b011 -> TPEND set and io_irq high every 4 cycles; W1C of TPEND in the same cycle as a set leaves TPEND=1.
REQ-034 Read 16'hFFF0 with BASE_ADDR=0 -> ack, data 0, ERR=1; W1C 16'h0010 to STATUS -> ERR=0.
REQ-035 Assert reset during ACK -> io_acknowledge=0 next cycle, all registers at reset values, FIFO empty.
